// File: rtl/irq_aggregator_pkg.sv
// irq_aggregator shared definitions.
// Register map, bus widths and ACTIVE field layout.
package irq_aggregator_pkg;

    localparam int DATA_W           = 16;
    localparam int ADDR_W           = 3;
    localparam int ACTIVE_VALID_BIT = 15;

    localparam logic [ADDR_W-1:0] ADDR_PENDING  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OVERRUN  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_RAW      = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_SW_SET   = 3'd6;

endpackage

// File: rtl/irq_aggregator_if.sv
// Avalon-MM slave bus of the irq aggregator.
// Same shape and timing as the interval timer's s1 port.
interface irq_aggregator_if;
    import irq_aggregator_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/irq_aggregator_sync_edge.sv
// Per-channel synchroniser with rising-edge detect.
// s is the synchronised level, rise pulses one clock on a 0->1 of s.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: sync, latch, mask and combine up to 16 irqs.
// Registers are exposed on a 16-bit Avalon-MM slave with 1-cycle reads.
module irq_aggregator
    import irq_aggregator_pkg::*;
#(
    parameter int          NUM_IRQ        = 4,
    parameter int          SYNC_STAGES    = 2,
    parameter logic [15:0] EDGE_SEL_RESET = 16'h0001
) (
    input  logic                clk,
    input  logic                reset_n,
    irq_aggregator_if.slave     bus,
    input  logic [NUM_IRQ-1:0]  irq_in,
    output logic                irq
);

    logic [NUM_IRQ-1:0] s, rise;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .reset_n(reset_n),
            .irq_in (irq_in[g]),
            .s      (s[g]),
            .rise   (rise[g])
        );
    end

    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_IRQ-1:0] overrun_q, overrun_d;
    logic [DATA_W-1:0]  readdata_q, readdata_d;
    logic               irq_q, irq_d;

    logic               wr;
    logic [NUM_IRQ-1:0] wdata;
    logic [NUM_IRQ-1:0] w1c, w1c_ovr, sw_set, set;
    logic [NUM_IRQ-1:0] pe;
    logic               act_any;
    logic [3:0]         act_idx;

    // Upper writedata bits are don't-care when NUM_IRQ < 16.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        wr      = bus.chipselect & ~bus.write_n;
        wdata   = bus.writedata[NUM_IRQ-1:0];
        w1c     = '0;
        w1c_ovr = '0;
        sw_set  = '0;
        if (wr && bus.address == ADDR_PENDING) w1c     = wdata;
        if (wr && bus.address == ADDR_OVERRUN) w1c_ovr = wdata;
        if (wr && bus.address == ADDR_SW_SET)  sw_set  = wdata;

        set        = (edge_sel_q & rise) | (~edge_sel_q & s) | sw_set;
        pending_d  = set | (pending_q & ~w1c);
        overrun_d  = (edge_sel_q & rise & pending_q)
                   | (overrun_q & ~w1c_ovr);

        enable_d   = enable_q;
        edge_sel_d = edge_sel_q;
        if (wr && bus.address == ADDR_ENABLE)   enable_d   = wdata;
        if (wr && bus.address == ADDR_EDGE_SEL) edge_sel_d = wdata;

        pe    = pending_q & enable_q;
        irq_d = |pe;
    end

    // Lowest index wins: scan high to low so the last hit is the lowest.
    always_comb begin
        act_any = |pe;
        act_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pe[i]) act_idx = 4'(i);
        end
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_PENDING:  readdata_d = DATA_W'(pending_q);
            ADDR_ENABLE:   readdata_d = DATA_W'(enable_q);
            ADDR_EDGE_SEL: readdata_d = DATA_W'(edge_sel_q);
            ADDR_ACTIVE: begin
                readdata_d[ACTIVE_VALID_BIT] = act_any;
                readdata_d[3:0]              = act_idx;
            end
            ADDR_OVERRUN:  readdata_d = DATA_W'(overrun_q);
            ADDR_RAW:      readdata_d = DATA_W'(s);
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            enable_q   <= '0;
            edge_sel_q <= EDGE_SEL_RESET[NUM_IRQ-1:0];
            overrun_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            edge_sel_q <= edge_sel_d;
            overrun_q  <= overrun_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Bench for irq_aggregator: directed scenarios plus randomized
// traffic checked against a cycle-level reference model.
module tb_irq_aggregator;
    import irq_aggregator_pkg::*;

    localparam int          NI   = 4;
    localparam int          SS   = 2;
    localparam logic [15:0] MASK = 16'h000F;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [NI-1:0] irq_in  = '0;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    irq_aggregator_if bus();

    irq_aggregator #(
        .NUM_IRQ(NI), .SYNC_STAGES(SS), .EDGE_SEL_RESET(16'h0001)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .irq_in (irq_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Reference model: registers as 16-bit words, inputs as a sample queue.
    logic [15:0] m_pend, m_en, m_edge, m_ovr, m_rd, m_s, m_prev;
    logic        m_irq;
    logic [15:0] hist[$];

    function automatic logic [15:0] m_read(input logic [2:0] a,
        input logic [15:0] pend, en, edg, ovr, sv);
        logic [15:0] pe, r;
        pe = pend & en;
        r  = 16'h0;
        case (a)
            3'd0: r = pend;
            3'd1: r = en;
            3'd2: r = edg;
            3'd3: begin
                for (int i = 0; i < NI; i++)
                    if (pe[i] && r == 16'h0) r = 16'h8000 | 16'(i);
            end
            3'd4: r = ovr;
            3'd5: r = sv;
            default: r = 16'h0;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        logic        w;
        logic [2:0]  a;
        logic [15:0] d, rs, st;
        if (!reset_n) begin
            m_pend <= 0; m_en <= 0; m_ovr <= 0;
            m_edge <= 16'h0001 & MASK;
            m_rd <= 0; m_irq <= 0; m_s <= 0; m_prev <= 0;
            hist.delete();
        end else begin
            w  = bus.chipselect && !bus.write_n;
            a  = bus.address;
            d  = bus.writedata & MASK;
            rs = m_s & ~m_prev;
            st = (m_edge & rs) | (~m_edge & m_s)
               | ((w && a == 3'd6) ? d : 16'h0);
            m_rd   <= m_read(a, m_pend, m_en, m_edge, m_ovr, m_s);
            m_irq  <= |(m_pend & m_en);
            m_pend <= (st | (m_pend & ~((w && a == 3'd0) ? d : 16'h0))) & MASK;
            m_ovr  <= ((m_edge & rs & m_pend)
                     | (m_ovr & ~((w && a == 3'd4) ? d : 16'h0))) & MASK;
            if (w && a == 3'd1) m_en   <= d;
            if (w && a == 3'd2) m_edge <= d;
            hist.push_front(16'(irq_in));
            if (hist.size() > SS) void'(hist.pop_back());
            m_prev <= m_s;
            m_s    <= (hist.size() == SS) ? hist[SS-1] : 16'h0;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.address = a; bus.writedata = d;
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic pulse(input int b);
        irq_in[b] = 1'b1;
        @(negedge clk);
        irq_in[b] = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v, exp;
        bus.address = 0; bus.chipselect = 0;
        bus.write_n = 1; bus.writedata = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wr(3'd1, 16'h000F);
        wr(3'd6, 16'h0003);
        wr(3'd2, 16'h000E);
        @(negedge clk);
        bus.address = 3'd0; bus.writedata = 16'h000F;
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL rst_async_irq got=%b exp=0", irq);
        end
        checks++;
        if (bus.readdata !== 16'h0) begin
            failures++;
            $display("FAIL rst_async_rd got=%h exp=0000", bus.readdata);
        end
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            exp = (i == 2) ? 16'h0001 : 16'h0000;
            checks++;
            if (v !== exp) begin
                failures++;
                $display("FAIL rst_reg%0d got=%h exp=%h", i, v, exp);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL rst_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_edge_path();
        logic [15:0] v;
        wr(3'd1, 16'h0001);
        irq_in[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) irq_in[0] = 1'b0;
            if (i >= 3) begin
                checks++;
                if (irq !== (i == 4)) begin
                    failures++;
                    $display("FAIL edge_lat_c%0d got=%b exp=%b", i, irq, i == 4);
                end
            end
        end
        rd(3'd0, v);
        checks++;
        if (v !== 16'h0001) begin
            failures++; $display("FAIL edge_pend got=%h exp=0001", v);
        end
        rd(3'd3, v);
        checks++;
        if (v !== 16'h8000) begin
            failures++; $display("FAIL edge_active got=%h exp=8000", v);
        end
        wr(3'd0, 16'h0001);
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL edge_w1c_c1 got=%b exp=1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL edge_w1c_c2 got=%b exp=0", irq);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] v;
        pulse(0);
        repeat (5) @(negedge clk);
        pulse(0);
        repeat (5) @(negedge clk);
        rd(3'd4, v);
        checks++;
        if (v !== 16'h0001) begin
            failures++; $display("FAIL ovr_set got=%h exp=0001", v);
        end
        irq_in[0] = 1'b1;
        @(negedge clk);
        irq_in[0] = 1'b0;
        @(negedge clk);
        wr(3'd4, 16'h0001);
        repeat (2) @(negedge clk);
        rd(3'd4, v);
        checks++;
        if (v !== 16'h0001) begin
            failures++; $display("FAIL ovr_set_wins got=%h exp=0001", v);
        end
        wr(3'd4, 16'h0001);
        rd(3'd4, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++; $display("FAIL ovr_w1c got=%h exp=0000", v);
        end
        wr(3'd0, 16'h0001);
        rd(3'd0, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++; $display("FAIL ovr_pend_clr got=%h exp=0000", v);
        end
    endtask

    task automatic test_level();
        logic [15:0] v;
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0002);
        irq_in[1] = 1'b1;
        repeat (4) @(negedge clk);
        wr(3'd0, 16'h0002);
        rd(3'd0, v);
        checks++;
        if (v !== 16'h0002) begin
            failures++; $display("FAIL lvl_hold got=%h exp=0002", v);
        end
        irq_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        rd(3'd0, v);
        checks++;
        if (v !== 16'h0002) begin
            failures++; $display("FAIL lvl_latched got=%h exp=0002", v);
        end
        wr(3'd0, 16'h0002);
        rd(3'd0, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++; $display("FAIL lvl_clr got=%h exp=0000", v);
        end
        rd(3'd4, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++; $display("FAIL lvl_no_ovr got=%h exp=0000", v);
        end
    endtask

    task automatic test_priority();
        logic [15:0] v;
        wr(3'd1, 16'h0008);
        wr(3'd6, 16'h000C);
        rd(3'd3, v);
        checks++;
        if (v !== 16'h8003) begin
            failures++; $display("FAIL prio_mask got=%h exp=8003", v);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL prio_irq got=%b exp=1", irq);
        end
        wr(3'd1, 16'h000C);
        rd(3'd3, v);
        checks++;
        if (v !== 16'h8002) begin
            failures++; $display("FAIL prio_low got=%h exp=8002", v);
        end
        wr(3'd0, 16'hFFFF);
        rd(3'd0, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++; $display("FAIL prio_clr got=%h exp=0000", v);
        end
    endtask

    task automatic test_read_timing();
        logic [15:0] v;
        wr(3'd1, 16'h0000);
        irq_in = 4'b1010;
        repeat (4) @(negedge clk);
        rd(3'd7, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++; $display("FAIL rd_addr7 got=%h exp=0000", v);
        end
        rd(3'd5, v);
        checks++;
        if (v !== 16'h000A) begin
            failures++; $display("FAIL rd_raw got=%h exp=000A", v);
        end
        rd(3'd6, v);
        checks++;
        if (v !== 16'h0000) begin
            failures++; $display("FAIL rd_swset got=%h exp=0000", v);
        end
        irq_in = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            checks++;
            if (bus.readdata !== m_rd) begin
                failures++;
                $display("FAIL rand_rd cyc=%0d got=%h exp=%h",
                         n, bus.readdata, m_rd);
            end
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("FAIL rand_irq cyc=%0d got=%b exp=%b",
                         n, irq, m_irq);
            end
            if ($urandom_range(0, 3) == 0) irq_in = NI'($urandom);
            bus.chipselect = ($urandom_range(0, 2) == 0);
            bus.write_n    = 1'($urandom_range(0, 1));
            bus.address    = 3'($urandom);
            bus.writedata  = 16'($urandom);
            @(negedge clk);
        end
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_edge_path();
        test_overrun();
        test_level();
        test_priority();
        test_read_timing();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_aggregator.md
Name: irq_aggregator

Overview:
- Avalon-MM interrupt aggregator that sits directly downstream of the interval timer and the other peripheral irq sources in the MN SoC host.
- Synchronises up to 16 irq inputs, with each input selectable as rising-edge or level sensitive.
- Latches pending sources, masks them, and drives one combined irq to the host CPU.
- Exposes pending, enable, overrun and highest-priority-active registers on a 16-bit slave port with the same timing as the timer's s1 port.

Parameters:
- NUM_IRQ, 4, number of irq inputs, legal range 1..16.
- SYNC_STAGES, 2, synchroniser depth per input, legal range 2..3.
- EDGE_SEL_RESET, 16'h0001, reset value of EDGE_SEL (bit 0 edge = timer irq).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq_in  in  NUM_IRQ  raw source interrupts, asynchronous to clk allowed.
- irq  out  1  combined interrupt to CPU, registered.

Behaviour:
- Reset: readdata=0, irq=0, PENDING=0, ENABLE=0, OVERRUN=0, EDGE_SEL=EDGE_SEL_RESET, synchroniser and edge-history flops=0. One clock, reset is asynchronous and active-low; all flops clear immediately on reset_n=0, including mid-transaction.
- Write strobe = chipselect && !write_n. Writes take effect on the next clk edge.
- Reads:
  - readdata <= read_mux(address) every cycle, independent of chipselect, so read latency is 1 cycle.
  - Reads have no side effects.
  - Bits at or above NUM_IRQ read 0 and ignore writes.
- Register map:
  - 0 PENDING: R, write-1-to-clear.
  - 1 ENABLE: RW.
  - 2 EDGE_SEL: RW; 1 = rising edge, 0 = level.
  - 3 ACTIVE: R; bit15 = any(PENDING&ENABLE), [3:0] = lowest index set in PENDING&ENABLE, else 0.
  - 4 OVERRUN: R, write-1-to-clear.
  - 5 RAW: R; synchronised input levels.
  - 6 SW_SET: W; a 1 sets that PENDING bit. Reads 0.
  - 7: reads 0, writes ignored.
- Synchronisation: s[i] = irq_in[i] delayed SYNC_STAGES clocks. prev[i] = s[i] delayed 1 clock. rise[i] = s[i] & ~prev[i].
- Set condition, per bit: set[i] = (EDGE_SEL[i] ? rise[i] : s[i]) | sw_set[i].
- PENDING update: PENDING[i] <= set[i] | (PENDING[i] & ~w1c[i]).
  - Set wins over a same-cycle W1C.
  - In level mode, W1C has no lasting effect while s[i]=1.
- OVERRUN: OVERRUN[i] <= (EDGE_SEL[i] & rise[i] & PENDING[i]) | (OVERRUN[i] & ~w1c_ovr[i]).
  - Set wins over clear.
  - Level mode never sets OVERRUN.
- Masking: ENABLE gates only irq and ACTIVE. PENDING latches regardless of ENABLE.
- irq timing: irq <= |(PENDING & ENABLE), registered. Earliest irq after an irq_in rising edge is SYNC_STAGES+2 cycles:
  - SYNC_STAGES cycles for synchronisation;
  - 1 cycle for the PENDING flop;
  - 1 cycle for the irq flop.
- EDGE_SEL change does not alter PENDING. prev keeps tracking s, so switching mode creates no spurious edge.
- Priority: lowest index wins. ACTIVE is computed combinationally from current state and registered through readdata.

Decomposition:
- Package irq_aggregator_pkg:
  - register address constants ADDR_PENDING..ADDR_SW_SET;
  - DATA_W=16;
  - ACTIVE_VALID_BIT=15.
- Sub-module irq_sync_edge (one per channel, generate loop):
  - SYNC_STAGES flop chain plus prev flop;
  - outputs s and rise.

Test Plan:
- Reset defaults: assert reset_n=0 mid-write, then release → all registers read 0 except EDGE_SEL=16'h0001; irq=0.
- Edge path: ENABLE=1; pulse irq_in[0] for 1 cycle (SYNC_STAGES=2) → irq=1 exactly 4 cycles after the rising edge, PENDING=0x0001, ACTIVE=0x8000. Write PENDING=0x0001 → irq=0 two cycles later.
- Overrun: with PENDING[0]=1, pulse irq_in[0] again → OVERRUN=0x0001. W1C of OVERRUN coincident with a new edge → OVERRUN stays 0x0001.
- Level mode: EDGE_SEL=0, ENABLE=0x0002, hold irq_in[1]=1. W1C PENDING=0x0002 → PENDING reads 0x0002 still. Drop irq_in[1], then W1C → PENDING reads 0.
- Priority/mask: SW_SET=0x000C with ENABLE=0x0008 → ACTIVE=0x8003, irq=1. ENABLE=0x000C → ACTIVE=0x8002.
- Read timing: address=5 with irq_in=4'b1010 stable → readdata=0x000A one cycle after address is presented; address=7 → 0x0000.
